// File: rtl/slc3_bridge_pkg.sv
// Shared types and constants for the SLC-3 memory/I-O bridge.
package slc3_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM_WR,
    MEM_RD,
    IO,
    DONE,
    HOLD
  } bridge_state_t;

  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

  // Active-low gfedcba glyphs for hex digits 0-F
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_seg7
  import slc3_bridge_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG7_GLYPH[nib];

endmodule

// File: rtl/slc3_mem_bridge.sv
// SLC-3 core bus to synchronous memory bridge with ready handshake,
// configurable read latency and a memory-mapped switch/hex I/O register.
module slc3_mem_bridge
  import slc3_bridge_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                MEM_AW     = 10,
  parameter int                MEM_LAT    = 2,
  parameter int                SW_W       = 10,
  parameter int                HEX_DIGITS = 4,
  parameter logic [ADDR_W-1:0] IO_ADDR    = ADDR_W'(IO_ADDR_DEF)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    cpu_oe,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_rden,
  output logic                    mem_wren,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic [SW_W-1:0]         SW,
  output logic [7*HEX_DIGITS-1:0] HEX
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int HEX_W = 4 * HEX_DIGITS;

  bridge_state_t      state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               is_wr;
  logic [HEX_W-1:0]   hex_reg;
  logic [SW_W-1:0]    sw_meta;
  logic [SW_W-1:0]    sw_sync;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      is_wr     <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hex_reg   <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      // Strobes and ready are single-cycle pulses unless set below
      cpu_ready <= 1'b0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_we || cpu_oe) begin
            mem_addr  <= cpu_addr[MEM_AW-1:0];
            mem_wdata <= cpu_wdata;
            is_wr     <= cpu_we;
            if (cpu_addr == IO_ADDR) begin
              state <= IO;
            end else if (cpu_we) begin
              state    <= MEM_WR;
              mem_wren <= 1'b1;
            end else begin
              state    <= MEM_RD;
              mem_rden <= 1'b1;
              wait_cnt <= CNT_W'(MEM_LAT - 1);
            end
          end
        end
        MEM_WR: state <= DONE;
        MEM_RD: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            state     <= DONE;
          end
        end
        IO: begin
          // The captured write data doubles as the I/O write payload
          if (is_wr) hex_reg <= mem_wdata[HEX_W-1:0];
          else       cpu_rdata <= DATA_W'(sw_sync);
          state <= DONE;
        end
        DONE: begin
          cpu_ready <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // One access per strobe assertion: wait for the core to let go
          if (!cpu_oe && !cpu_we) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_digit
    hex_seg7 u_seg (
      .nib (hex_reg[4*i +: 4]),
      .seg (HEX[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Directed self-checking bench for slc3_mem_bridge with default parameters.
module tb_slc3_mem_bridge;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_oe, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rden, mem_wren;
  logic [15:0] mem_rdata;
  logic [9:0]  SW;
  logic [27:0] HEX;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [1024];
  logic [15:0] rd_q;

  logic [9:0]  wr_addr_seen;
  logic [15:0] wr_data_seen;
  logic [15:0] rdata_seen;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;

  slc3_mem_bridge dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_oe    (cpu_oe),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rden  (mem_rden),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata),
    .SW        (SW),
    .HEX       (HEX)
  );

  always #5 Clk = ~Clk;

  // Synchronous RAM: registered read, output held until the next read
  always @(posedge Clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    if (mem_rden) rd_q <= mem[mem_addr];
  end
  assign mem_rdata = rd_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one access, keep the strobe for 'hold' cycles past ready, then
  // release and idle 3 cycles; count pulses over the whole window.
  task automatic access(input logic we, input logic oe, input logic [15:0] addr,
                        input logic [15:0] wd, input int hold,
                        output int lat, output int n_rd, output int n_wr,
                        output int n_rdy);
    lat = -1; n_rd = 0; n_wr = 0; n_rdy = 0;
    @(negedge Clk);
    cpu_we = we; cpu_oe = oe; cpu_addr = addr; cpu_wdata = wd;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (mem_rden) n_rd++;
      if (mem_wren) begin
        n_wr++;
        wr_addr_seen = mem_addr;
        wr_data_seen = mem_wdata;
      end
      if (cpu_ready) begin
        n_rdy++;
        if (lat < 0) begin
          lat = c - 1;
          rdata_seen = cpu_rdata;
        end
      end
      if (lat >= 0 && (c - 1) >= lat + hold) break;
    end
    @(negedge Clk);
    cpu_we = 1'b0; cpu_oe = 1'b0;
    cpu_addr = 16'h3C3C; cpu_wdata = 16'h5A5A;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      if (mem_rden) n_rd++;
      if (mem_wren) n_wr++;
      if (cpu_ready) n_rdy++;
    end
  endtask

  initial begin
    int lat, n_rd, n_wr, n_rdy;
    int rdy_cnt;

    Reset = 1'b1; cpu_oe = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0; cpu_wdata = 16'h0; SW = 10'h0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 16'h0000);
    check("rst_rden", mem_rden, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_maddr", mem_addr, 10'h000);
    check("rst_hex", HEX, {G0, G0, G0, G0});
    @(negedge Clk);
    Reset = 1'b0;

    // Memory write
    access(1'b1, 1'b0, 16'h0005, 16'hBEEF, 0, lat, n_rd, n_wr, n_rdy);
    check("wr_lat", lat, 2);
    check("wr_wren_cnt", n_wr, 1);
    check("wr_rden_cnt", n_rd, 0);
    check("wr_addr", wr_addr_seen, 10'h005);
    check("wr_data", wr_data_seen, 16'hBEEF);
    check("wr_rdy_cnt", n_rdy, 1);

    // Aliased memory read
    access(1'b0, 1'b1, 16'h0405, 16'h0000, 0, lat, n_rd, n_wr, n_rdy);
    check("rd_lat", lat, 3);
    check("rd_data", rdata_seen, 16'hBEEF);
    check("rd_rden_cnt", n_rd, 1);
    check("rd_held", cpu_rdata, 16'hBEEF);

    // IO read of synchronised switches
    @(negedge Clk);
    SW = 10'h2A5;
    repeat (3) @(posedge Clk);
    access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, lat, n_rd, n_wr, n_rdy);
    check("io_rd_lat", lat, 2);
    check("io_rd_data", rdata_seen, 16'h02A5);
    check("io_rd_rden", n_rd, 0);

    // IO write to hex display
    access(1'b1, 1'b0, 16'hFFFF, 16'h1234, 0, lat, n_rd, n_wr, n_rdy);
    check("io_wr_lat", lat, 2);
    check("io_wr_wren", n_wr, 0);
    check("io_wr_dig0", HEX[6:0], G4);
    check("io_wr_dig3", HEX[27:21], G1);
    check("io_wr_hex", HEX, {G1, G2, G3, G4});
    check("io_wr_rdata", cpu_rdata, 16'h02A5);

    // Strobe held long after ready
    access(1'b0, 1'b1, 16'h0005, 16'h0000, 10, lat, n_rd, n_wr, n_rdy);
    check("hold_rden_cnt", n_rd, 1);
    check("hold_rdy_cnt", n_rdy, 1);
    check("hold_data", rdata_seen, 16'hBEEF);

    // Both strobes: write wins
    access(1'b1, 1'b1, 16'h0010, 16'hA5A5, 0, lat, n_rd, n_wr, n_rdy);
    check("both_wren", n_wr, 1);
    check("both_rden", n_rd, 0);
    check("both_lat", lat, 2);
    access(1'b0, 1'b1, 16'h0010, 16'h0000, 0, lat, n_rd, n_wr, n_rdy);
    check("both_readback", rdata_seen, 16'hA5A5);

    // Reset while MEM_RD counter is 1
    @(negedge Clk);
    cpu_oe = 1'b1; cpu_addr = 16'h0010;
    @(posedge Clk); #1;
    check("mid_rden", mem_rden, 1'b1);
    Reset = 1'b1;
    #1;
    check("mid_rst_ready", cpu_ready, 1'b0);
    check("mid_rst_rden", mem_rden, 1'b0);
    check("mid_rst_rdata", cpu_rdata, 16'h0000);
    check("mid_rst_maddr", mem_addr, 10'h000);
    check("mid_rst_hex", HEX, {G0, G0, G0, G0});
    rdy_cnt = 0;
    @(negedge Clk);
    cpu_oe = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      if (cpu_ready) rdy_cnt++;
    end
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      if (cpu_ready) rdy_cnt++;
    end
    check("mid_no_ready", rdy_cnt, 0);
    access(1'b0, 1'b1, 16'h0005, 16'h0000, 0, lat, n_rd, n_wr, n_rdy);
    check("post_rst_lat", lat, 3);
    check("post_rst_data", rdata_seen, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
